ucore_mem_responder: RTL and testbench



---
 rtl/ucore_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_ucore_mem_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucore_mem_responder.sv
// ---------------------------------------------------------------------------
// ucore_mem_responder
//
// Target end of a ucore core's request/response port. Accepts one request at
// a time, services it against a small register-array memory, and returns a
// response after a fixed latency (1 cycle for writes, RD_LATENCY for reads).
//
// Parameters
//   DATA_W      data word width
//   ADDR_W      word address width
//   DEPTH       implemented words (1..2**ADDR_W); higher addresses are errors
//   RD_LATENCY  read response latency in cycles (1..15)
//
// Ports
//   clk        clock, rising edge
//   aresetn    asynchronous active-low reset (clears memory and outputs)
//   req_valid  core presents a request
//   req_write  1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_ready  responder can accept a request (registered)
//   rsp_valid  response available (registered)
//   rsp_rdata  read data, 0 for writes and errors (registered)
//   rsp_error  address was out of range (registered)
//   rsp_ready  core consumes the response
// ---------------------------------------------------------------------------
module ucore_mem_responder #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    input  logic              rsp_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L     = (ADDR_W + 1)'(DEPTH);
    // Counter preload for the WAIT state; unused when RD_LATENCY is 1.
    localparam logic [3:0]      WAIT_LOAD   = 4'(RD_LATENCY - 2);
    localparam bit              DIRECT_READ = (RD_LATENCY == 1);

    state_t              state_reg;
    logic [3:0]          wait_cnt_reg;
    logic [DATA_W-1:0]   pend_rdata_reg;
    logic                pend_error_reg;

    logic [DEPTH*DATA_W-1:0] mem_flat;
    logic                    accept;
    logic                    in_range;
    logic [DATA_W-1:0]       rd_word;
    logic [DATA_W-1:0]       rd_data_next;

    // req_ready is only ever high in IDLE, so this is the acceptance edge.
    assign accept   = req_valid && req_ready;
    assign in_range = ({1'b0, req_addr} < DEPTH_L);

    // One register per word so every word can be cleared by reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            logic [DATA_W-1:0] word_reg;

            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn) begin
                    word_reg <= '0;
                end else if (accept && req_write && in_range &&
                             (req_addr == ADDR_W'(gi))) begin
                    word_reg <= req_wdata;
                end
            end

            assign mem_flat[gi*DATA_W +: DATA_W] = word_reg;
        end
    endgenerate

    // Read mux over the implemented words; out-of-range addresses yield 0.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req_addr == ADDR_W'(i)) begin
                rd_word = mem_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // Writes and errors always return zero data.
    assign rd_data_next = (in_range && !req_write) ? rd_word : '0;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= ST_IDLE;
            wait_cnt_reg   <= '0;
            pend_rdata_reg <= '0;
            pend_error_reg <= 1'b0;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_error      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (req_write || DIRECT_READ) begin
                            state_reg <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rd_data_next;
                            rsp_error <= !in_range;
                        end else begin
                            // Data is captured now so the response reflects
                            // memory as it was at acceptance.
                            state_reg      <= ST_WAIT;
                            wait_cnt_reg   <= WAIT_LOAD;
                            pend_rdata_reg <= rd_data_next;
                            pend_error_reg <= !in_range;
                        end
                    end
                end

                ST_WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        state_reg <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_rdata_reg;
                        rsp_error <= pend_error_reg;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_error <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucore_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_ucore_mem_responder
//
// Four responder instances (read latencies 2, 1, 4, 15) share clock and the
// request address/data bus; each has its own valid, reset and rsp_ready.
// Stimulus pushes the expected response into a per-instance queue; a monitor
// pops and compares whenever an instance raises rsp_valid, and also checks
// hold stability under backpressure and clearing after the handshake.
// ---------------------------------------------------------------------------
module tb_ucore_mem_responder;

    localparam int NDUT = 4;

    typedef struct {
        bit          err;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    logic              clk = 1'b0;
    logic [NDUT-1:0]   aresetn_v   = '0;
    logic [NDUT-1:0]   req_valid_v = '0;
    logic [NDUT-1:0]   rsp_ready_v = '1;
    logic              req_write   = 1'b0;
    logic [3:0]        req_addr    = '0;
    logic [31:0]       req_wdata   = '0;
    logic [NDUT-1:0]   req_ready_v;
    logic [NDUT-1:0]   rsp_valid_v;
    logic [NDUT-1:0]   rsp_error_v;
    logic [31:0]       rsp_rdata_v [NDUT];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    exp_t            exp_q [NDUT][$];
    bit [NDUT-1:0]   active = '0;
    logic [NDUT-1:0] hs_prev = '0;
    logic [31:0]     hold_data [NDUT];
    logic [NDUT-1:0] hold_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) hs_prev <= rsp_valid_v & rsp_ready_v;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            ucore_mem_responder #(
                .DATA_W    (32),
                .ADDR_W    (4),
                .DEPTH     (12),
                .RD_LATENCY((gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 4 : 15)
            ) u_dut (
                .clk       (clk),
                .aresetn   (aresetn_v[gi]),
                .req_valid (req_valid_v[gi]),
                .req_write (req_write),
                .req_addr  (req_addr),
                .req_wdata (req_wdata),
                .req_ready (req_ready_v[gi]),
                .rsp_valid (rsp_valid_v[gi]),
                .rsp_rdata (rsp_rdata_v[gi]),
                .rsp_error (rsp_error_v[gi]),
                .rsp_ready (rsp_ready_v[gi])
            );
        end
    endgenerate

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 15;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s", name);
    endtask

    // Wait for the instance to be ready, present one request for one edge,
    // and queue the response it must produce.
    task automatic issue(input int d, input bit wr, input logic [3:0] a,
                         input logic [31:0] wd, input bit e_err, input logic [31:0] e_data);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready_v[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_v[d]) begin
            fail_now($sformatf("u%0d_issue_timeout addr=%0d", d, a));
            return;
        end
        e.err  = e_err;
        e.data = e_data;
        e.lat  = wr ? 1 : lat_of(d);
        e.acc  = cyc;
        exp_q[d].push_back(e);
        $display("u%0d %s addr=%0d wdata=%h expect err=%0d rdata=%h lat=%0d",
                 d, wr ? "WR" : "RD", a, wd, e_err, e_data, e.lat);
        #1;
        req_valid_v[d] = 1'b1;
        req_write      = wr;
        req_addr       = a;
        req_wdata      = wd;
        @(negedge clk);
        #1;
        req_valid_v[d] = 1'b0;
    endtask

    task automatic wait_all_idle();
        int n;
        n = 0;
        while (n < 200 && (req_ready_v != '1 || exp_q[0].size() != 0 || exp_q[1].size() != 0 ||
                           exp_q[2].size() != 0 || exp_q[3].size() != 0)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("idle_timeout");
    endtask

    // Response monitor
    always @(negedge clk) begin
        exp_t cur;
        for (int i = 0; i < NDUT; i++) begin
            if (!aresetn_v[i]) begin
                active[i] = 1'b0;
            end else if (rsp_valid_v[i]) begin
                chk($sformatf("u%0d_ready_with_valid", i), req_ready_v[i], 0);
                if (!active[i]) begin
                    if (exp_q[i].size() == 0) begin
                        fail_now($sformatf("u%0d_unexpected_rsp rdata=%h err=%0d",
                                           i, rsp_rdata_v[i], rsp_error_v[i]));
                    end else begin
                        cur = exp_q[i].pop_front();
                        chk($sformatf("u%0d_latency", i), cyc - cur.acc, cur.lat);
                        chk($sformatf("u%0d_rsp_error", i), rsp_error_v[i], cur.err);
                        chk($sformatf("u%0d_rsp_rdata", i), rsp_rdata_v[i], cur.data);
                        $display("u%0d RSP rdata=%h err=%0d lat=%0d", i,
                                 rsp_rdata_v[i], rsp_error_v[i], cyc - cur.acc);
                    end
                    active[i]    = 1'b1;
                    hold_data[i] = rsp_rdata_v[i];
                    hold_err[i]  = rsp_error_v[i];
                end else begin
                    chk($sformatf("u%0d_hold_rdata", i), rsp_rdata_v[i], hold_data[i]);
                    chk($sformatf("u%0d_hold_error", i), rsp_error_v[i], hold_err[i]);
                end
            end else if (active[i]) begin
                if (!hs_prev[i]) fail_now($sformatf("u%0d_rsp_dropped_without_handshake", i));
                chk($sformatf("u%0d_clear_after_hs", i), {rsp_error_v[i], rsp_rdata_v[i]}, 0);
                active[i] = 1'b0;
            end
        end
    end

    initial begin
        int n;

        // Reset held for three cycles on every instance.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++)
                chk($sformatf("u%0d_reset_outputs", d),
                    {req_ready_v[d], rsp_valid_v[d], rsp_error_v[d], rsp_rdata_v[d]}, 0);
        end
        #1 aresetn_v = '1;
        @(negedge clk);
        chk("req_ready_after_release", req_ready_v, 4'hF);

        // Every word reads 0; addresses 12..15 are errors.
        for (int a = 0; a < 16; a++)
            issue(0, 1'b0, 4'(a), 32'h0, (a >= 12), 32'h0);

        // Write then read back.
        issue(0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 32'h0);
        issue(0, 1'b0, 4'd3, 32'h0, 1'b0, 32'hDEADBEEF);
        wait_all_idle();

        // Backpressure: response held for 5 cycles, a stray write is ignored.
        #1 rsp_ready_v[0] = 1'b0;
        issue(0, 1'b0, 4'd3, 32'h0, 1'b0, 32'hDEADBEEF);
        n = 0;
        while (!rsp_valid_v[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid_v[0]) fail_now("bp_rsp_timeout");
        #1;
        req_valid_v[0] = 1'b1;
        req_write      = 1'b1;
        req_addr       = 4'd3;
        req_wdata      = 32'h00000BAD;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_req_ready_low", req_ready_v[0], 0);
            chk("bp_rsp_valid_held", rsp_valid_v[0], 1);
        end
        #1;
        req_valid_v[0] = 1'b0;
        rsp_ready_v[0] = 1'b1;
        @(negedge clk);
        chk("bp_req_ready_after_hs", req_ready_v[0], 1);
        chk("bp_rsp_valid_after_hs", rsp_valid_v[0], 0);
        issue(0, 1'b0, 4'd3, 32'h0, 1'b0, 32'hDEADBEEF);

        // Out-of-range accesses leave memory untouched.
        issue(0, 1'b1, 4'd13, 32'h00001234, 1'b1, 32'h0);
        issue(0, 1'b0, 4'd12, 32'h0, 1'b1, 32'h0);
        issue(0, 1'b0, 4'd1, 32'h0, 1'b0, 32'h0);
        issue(0, 1'b0, 4'd3, 32'h0, 1'b0, 32'hDEADBEEF);
        wait_all_idle();

        // Latency sweep: 1, 2 and 15 cycles.
        issue(1, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        issue(0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        issue(3, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        issue(1, 1'b1, 4'd7, 32'h5A5A0001, 1'b0, 32'h0);
        issue(1, 1'b0, 4'd7, 32'h0, 1'b0, 32'h5A5A0001);
        wait_all_idle();

        // Reset in the middle of a 4-cycle read.
        issue(2, 1'b1, 4'd5, 32'hA5A5A5A5, 1'b0, 32'h0);
        issue(2, 1'b0, 4'd5, 32'h0, 1'b0, 32'hA5A5A5A5);
        issue(2, 1'b0, 4'd5, 32'h0, 1'b0, 32'hA5A5A5A5);
        @(negedge clk);
        #1 aresetn_v[2] = 1'b0;
        #1;
        chk("midreset_outputs",
            {req_ready_v[2], rsp_valid_v[2], rsp_error_v[2], rsp_rdata_v[2]}, 0);
        exp_q[2].delete();
        $display("u2 RESET asserted mid-read, pending response dropped");
        @(negedge clk);
        @(negedge clk);
        #1 aresetn_v[2] = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid_v[2]) n++;
        end
        chk("midreset_no_rsp_after_release", n, 0);
        issue(2, 1'b0, 4'd5, 32'h0, 1'b0, 32'h0);
        wait_all_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
